keystroke_sequencer: RTL and testbench

Parametrised PS/2 keystroke sequencer. It sits between the PS/2 receiver and the Enigma encryption state machine. It turns the raw scan-code byte stream into whole keystrokes, one per completed make/break pair, with E0-extended key support, selectable typematic-repeat handling and a programmable hold-off. Completed keystrokes are buffered in a FIFO and handed out over a valid/ready handshake, so bursts of typing are not lost while the consumer is busy.

---
 rtl/keystroke_pkg.sv | 25 ++
 rtl/keystroke_fifo.sv | 74 +++++++
 rtl/keystroke_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_keystroke_sequencer.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/keystroke_pkg.sv
// Shared types and constants for the PS/2 keystroke sequencer.
package keystroke_pkg;

  // Keystroke assembly states
  typedef enum logic [2:0] {
    IDLE,
    SKIP,
    MAKE,
    BREAK,
    HOLD
  } state_t;

  // PS/2 set-2 prefix bytes
  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] PS2_BREAK = 8'hF0;

  // One buffered keystroke: extended flag plus scan code
  typedef struct packed {
    logic       ext;
    logic [7:0] code;
  } key_entry_t;

  localparam int KEY_ENTRY_W = $bits(key_entry_t);

endpackage

// File: rtl/keystroke_fifo.sv
// Show-ahead FIFO for completed keystrokes. The head entry is visible
// combinationally from storage; when empty the last popped entry is held.
module keystroke_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 9
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_flush,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_data,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_data,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_rd_ptr;
  logic [AW-1:0]    r_wr_ptr;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_last;
  logic             w_pop;
  logic             w_push;

  // A pop frees a slot in the same cycle, so a push into a full FIFO
  // succeeds when it coincides with a pop.
  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CW'(DEPTH));
  assign w_pop   = i_pop && !o_empty;
  assign w_push  = i_push && (!o_full || w_pop);
  assign o_data  = o_empty ? r_last : r_mem[r_rd_ptr];
  assign o_count = r_count;

  // Storage array; contents are only meaningful between the pointers
  always_ff @(posedge i_clk) begin
    if (w_push && !i_flush) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointers, occupancy and last-popped entry; flush wins over push/pop
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_last   <= '0;
    end else if (i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_last   <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= (r_wr_ptr == AW'(DEPTH - 1)) ? '0 : r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == AW'(DEPTH - 1)) ? '0 : r_rd_ptr + AW'(1);
        r_last   <= r_mem[r_rd_ptr];
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/keystroke_sequencer.sv
// Turns the raw PS/2 scan-code stream into whole keystrokes (one per
// make/break pair), with E0 extension, repeat handling and a hold-off,
// and buffers them for a valid/ready consumer.
module keystroke_sequencer
  import keystroke_pkg::*;
#(
  parameter int FIFO_DEPTH     = 8,
  parameter int HOLDOFF_CYCLES = 5000,
  parameter int IGNORE_REPEAT  = 1
) (
  input  logic                            CLOCK_50,
  input  logic                            reset_n,
  input  logic                            clear,
  input  logic [7:0]                      rx_data,
  input  logic                            rx_valid,
  output logic [7:0]                      key_code,
  output logic                            key_ext,
  output logic                            key_valid,
  input  logic                            key_ready,
  output logic [7:0]                      held_code,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fill,
  output logic                            overflow
);

  localparam int               CNT_W     = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLDOFF_CYCLES - 1);

  state_t           r_state;
  state_t           w_state_next;
  logic             r_ext_pending;
  logic             w_ext_pending_next;
  logic [7:0]       r_history;
  logic [7:0]       w_history_next;
  logic             r_ext;
  logic             w_ext_next;
  logic [7:0]       r_held_code;
  logic [7:0]       w_held_code_next;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_next;
  logic             r_overflow;

  logic             w_push;
  key_entry_t       w_push_entry;
  key_entry_t       w_head_entry;
  logic             w_full;
  logic             w_empty;
  logic             w_pop;

  assign w_push_entry = {r_ext, r_history};
  assign w_pop        = key_ready && !w_empty;

  assign key_code  = w_head_entry.code;
  assign key_ext   = w_head_entry.ext;
  assign key_valid = !w_empty;
  assign held_code = r_held_code;
  assign overflow  = r_overflow;

  keystroke_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (KEY_ENTRY_W)
  ) u_fifo (
    .i_clk   (CLOCK_50),
    .i_rst_n (reset_n),
    .i_flush (clear),
    .i_push  (w_push),
    .i_data  (w_push_entry),
    .i_pop   (key_ready),
    .o_data  (w_head_entry),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (fill)
  );

  // Register the FSM state and the keystroke bookkeeping; clear beats everything
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= IDLE;
      r_ext_pending <= 1'b0;
      r_history     <= '0;
      r_ext         <= 1'b0;
      r_held_code   <= '0;
      r_count       <= '0;
    end else if (clear) begin
      r_state       <= IDLE;
      r_ext_pending <= 1'b0;
      r_history     <= '0;
      r_ext         <= 1'b0;
      r_held_code   <= '0;
      r_count       <= '0;
    end else begin
      r_state       <= w_state_next;
      r_ext_pending <= w_ext_pending_next;
      r_history     <= w_history_next;
      r_ext         <= w_ext_next;
      r_held_code   <= w_held_code_next;
      r_count       <= w_count_next;
    end
  end

  // Sticky flag for a keystroke lost because the buffer was full
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_overflow <= 1'b0;
    end else if (clear) begin
      r_overflow <= 1'b0;
    end else if (w_push && w_full && !w_pop) begin
      r_overflow <= 1'b1;
    end
  end

  // Decode the byte stream into make/break pairs and decide when to push
  always_comb begin
    w_state_next       = r_state;
    w_ext_pending_next = r_ext_pending;
    w_history_next     = r_history;
    w_ext_next         = r_ext;
    w_held_code_next   = r_held_code;
    w_count_next       = r_count;
    w_push             = 1'b0;

    case (r_state)
      IDLE: begin
        if (rx_valid) begin
          if (rx_data == PS2_EXT) begin
            w_ext_pending_next = 1'b1;
          end else if (rx_data == PS2_BREAK) begin
            w_state_next = SKIP;
          end else begin
            w_history_next     = rx_data;
            w_ext_next         = r_ext_pending;
            w_ext_pending_next = 1'b0;
            w_held_code_next   = rx_data;
            w_state_next       = MAKE;
          end
        end
      end

      SKIP: begin
        if (rx_valid && rx_data != PS2_EXT) begin
          w_state_next = IDLE;
        end
      end

      MAKE: begin
        if (rx_valid) begin
          if (rx_data == PS2_BREAK) begin
            w_state_next = BREAK;
          end else if (rx_data == r_history && IGNORE_REPEAT == 0) begin
            w_push = 1'b1;
          end
        end
      end

      BREAK: begin
        if (rx_valid) begin
          if (rx_data == r_history) begin
            w_push           = 1'b1;
            w_held_code_next = '0;
            w_count_next     = '0;
            w_state_next     = HOLD;
          end else if (rx_data != PS2_EXT) begin
            w_state_next = MAKE;
          end
        end
      end

      HOLD: begin
        w_count_next = r_count + CNT_W'(1);
        if (r_count == HOLD_LAST) begin
          w_state_next = IDLE;
        end
      end

      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_keystroke_sequencer.sv
// Bench for keystroke_sequencer: two instances (repeats dropped / repeats
// enqueued) share one stimulus stream and are compared every cycle with a
// keystroke-level reference model.
module tb_keystroke_sequencer;

  localparam int DEPTH = 4;
  localparam int HOLD  = 20;
  localparam int FW    = $clog2(DEPTH + 1);
  localparam int LISTN = 1024;

  logic          CLOCK_50  = 1'b0;
  logic          reset_n   = 1'b0;
  logic          clear     = 1'b0;
  logic [7:0]    rx_data   = 8'h00;
  logic          rx_valid  = 1'b0;
  logic          key_ready = 1'b0;

  logic [7:0]    keyCode0, keyCode1;
  logic          keyExt0, keyExt1;
  logic          keyValid0, keyValid1;
  logic [7:0]    heldCode0, heldCode1;
  logic [FW-1:0] fill0, fill1;
  logic          overflow0, overflow1;

  int testsRun    = 0;
  int testsFailed = 0;

  // Reference model state, one slot per instance (0: repeats dropped, 1: repeats enqueued)
  bit         mHeld       [2];
  logic [7:0] mHeldCode   [2];
  bit         mExtPending [2];
  bit         mKeyExt     [2];
  bit         mSawBreak   [2];
  bit         mOrphan     [2];
  int         mHoldLeft   [2];
  bit         mOverflow   [2];
  logic [8:0] mList       [2][LISTN];
  int         mHead       [2];
  int         mTail       [2];

  always #5 CLOCK_50 = ~CLOCK_50;

  keystroke_sequencer #(
    .FIFO_DEPTH     (DEPTH),
    .HOLDOFF_CYCLES (HOLD),
    .IGNORE_REPEAT  (1)
  ) dut0 (
    .CLOCK_50  (CLOCK_50),
    .reset_n   (reset_n),
    .clear     (clear),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .key_code  (keyCode0),
    .key_ext   (keyExt0),
    .key_valid (keyValid0),
    .key_ready (key_ready),
    .held_code (heldCode0),
    .fill      (fill0),
    .overflow  (overflow0)
  );

  keystroke_sequencer #(
    .FIFO_DEPTH     (DEPTH),
    .HOLDOFF_CYCLES (HOLD),
    .IGNORE_REPEAT  (0)
  ) dut1 (
    .CLOCK_50  (CLOCK_50),
    .reset_n   (reset_n),
    .clear     (clear),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .key_code  (keyCode1),
    .key_ext   (keyExt1),
    .key_valid (keyValid1),
    .key_ready (key_ready),
    .held_code (heldCode1),
    .fill      (fill1),
    .overflow  (overflow1)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    assert (observed === expected)
      else begin
        testsFailed++;
        $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
  endtask

  task automatic modelReset(input int i);
    mHeld[i]       = 1'b0;
    mHeldCode[i]   = 8'h00;
    mExtPending[i] = 1'b0;
    mKeyExt[i]     = 1'b0;
    mSawBreak[i]   = 1'b0;
    mOrphan[i]     = 1'b0;
    mHoldLeft[i]   = 0;
    mOverflow[i]   = 1'b0;
    mHead[i]       = 0;
    mTail[i]       = 0;
  endtask

  // One clock edge of keystroke-level behaviour for instance i
  task automatic modelStep(input int i, input bit v, input logic [7:0] b, input bit rdy);
    bit         pushReq;
    logic [8:0] entry;
    pushReq = 1'b0;
    entry   = 9'h000;
    if (mHoldLeft[i] > 0) begin
      mHoldLeft[i]--;
    end else if (mOrphan[i]) begin
      if (v && b != 8'hE0) mOrphan[i] = 1'b0;
    end else if (!mHeld[i]) begin
      if (v) begin
        if (b == 8'hE0) begin
          mExtPending[i] = 1'b1;
        end else if (b == 8'hF0) begin
          mOrphan[i] = 1'b1;
        end else begin
          mHeld[i]       = 1'b1;
          mHeldCode[i]   = b;
          mKeyExt[i]     = mExtPending[i];
          mExtPending[i] = 1'b0;
          mSawBreak[i]   = 1'b0;
        end
      end
    end else if (v) begin
      if (mSawBreak[i]) begin
        if (b == mHeldCode[i]) begin
          pushReq      = 1'b1;
          entry        = {mKeyExt[i], mHeldCode[i]};
          mHeld[i]     = 1'b0;
          mSawBreak[i] = 1'b0;
          mHoldLeft[i] = HOLD;
        end else if (b != 8'hE0) begin
          mSawBreak[i] = 1'b0;
        end
      end else if (b == 8'hF0) begin
        mSawBreak[i] = 1'b1;
      end else if (b == mHeldCode[i] && i == 1) begin
        pushReq = 1'b1;
        entry   = {mKeyExt[i], mHeldCode[i]};
      end
    end
    if (rdy && mTail[i] > mHead[i]) mHead[i]++;
    if (pushReq) begin
      if (mTail[i] - mHead[i] < DEPTH && mTail[i] < LISTN) begin
        mList[i][mTail[i]] = entry;
        mTail[i]++;
      end else begin
        mOverflow[i] = 1'b1;
      end
    end
  endtask

  task automatic checkAll();
    logic [7:0]    oCode, oHeld;
    logic          oExt, oValid, oOvf;
    logic [FW-1:0] oFill;
    logic [8:0]    head;
    for (int i = 0; i < 2; i++) begin
      if (i == 0) begin
        oCode = keyCode0; oExt = keyExt0; oValid = keyValid0;
        oHeld = heldCode0; oFill = fill0; oOvf = overflow0;
      end else begin
        oCode = keyCode1; oExt = keyExt1; oValid = keyValid1;
        oHeld = heldCode1; oFill = fill1; oOvf = overflow1;
      end
      checkOutput($sformatf("dut%0d key_valid", i), 32'(oValid), 32'(mTail[i] > mHead[i]));
      checkOutput($sformatf("dut%0d fill", i), 32'(oFill), 32'(mTail[i] - mHead[i]));
      checkOutput($sformatf("dut%0d overflow", i), 32'(oOvf), 32'(mOverflow[i]));
      checkOutput($sformatf("dut%0d held_code", i), 32'(oHeld), mHeld[i] ? 32'(mHeldCode[i]) : 32'h0);
      if (mTail[i] > mHead[i]) begin
        head = mList[i][mHead[i]];
        checkOutput($sformatf("dut%0d key_code", i), 32'(oCode), 32'(head[7:0]));
        checkOutput($sformatf("dut%0d key_ext", i), 32'(oExt), 32'(head[8]));
      end
    end
  endtask

  // One clock: drive inputs, advance the model on the edge, check at the falling edge
  task automatic applyStimulus(input bit v, input logic [7:0] b, input bit rdy);
    rx_valid  = v;
    rx_data   = b;
    key_ready = rdy;
    @(posedge CLOCK_50);
    for (int i = 0; i < 2; i++) begin
      if (clear) modelReset(i);
      else       modelStep(i, v, b, rdy);
    end
    @(negedge CLOCK_50);
    rx_valid = 1'b0;
    checkAll();
  endtask

  task automatic applyClear();
    clear = 1'b1;
    applyStimulus(1'b1, 8'hF0, 1'b1);
    clear = 1'b0;
    checkOutput("clear key_code0", 32'(keyCode0), 32'h0);
    checkOutput("clear key_ext1", 32'(keyExt1), 32'h0);
  endtask

  task automatic applyReset();
    reset_n = 1'b0;
    #2;
    modelReset(0);
    modelReset(1);
    checkAll();
    checkOutput("reset key_code0", 32'(keyCode0), 32'h0);
    checkOutput("reset key_code1", 32'(keyCode1), 32'h0);
    checkOutput("reset key_ext0", 32'(keyExt0), 32'h0);
    @(negedge CLOCK_50);
    @(negedge CLOCK_50);
    reset_n = 1'b1;
  endtask

  task automatic keystroke(input logic [7:0] b, input bit ext, input bit rdy);
    if (ext) applyStimulus(1'b1, 8'hE0, rdy);
    applyStimulus(1'b1, b, rdy);
    if (ext) applyStimulus(1'b1, 8'hE0, rdy);
    applyStimulus(1'b1, 8'hF0, rdy);
    applyStimulus(1'b1, b, rdy);
    repeat (HOLD + 1) applyStimulus(1'b0, 8'h00, rdy);
  endtask

  initial begin
    logic [7:0] pool [8];
    logic [7:0] drain1 [4];
    logic [7:0] drain2 [4];
    pool   = '{8'hE0, 8'hF0, 8'h1C, 8'h1C, 8'h15, 8'h75, 8'hF0, 8'h24};
    drain1 = '{8'h15, 8'h24, 8'h2D, 8'h1C};
    drain2 = '{8'h35, 8'h36, 8'h3C, 8'h3B};

    modelReset(0);
    modelReset(1);
    @(negedge CLOCK_50);
    #1;
    checkAll();
    checkOutput("por key_code0", 32'(keyCode0), 32'h0);
    @(negedge CLOCK_50);
    reset_n = 1'b1;

    // Repeats: dropped by dut0, enqueued by dut1
    applyStimulus(1'b1, 8'h1C, 1'b0);
    checkOutput("tp1 held after make", 32'(heldCode0), 32'h1C);
    applyStimulus(1'b1, 8'h1C, 1'b0);
    applyStimulus(1'b1, 8'h1C, 1'b0);
    applyStimulus(1'b1, 8'hF0, 1'b0);
    checkOutput("tp1 held before break", 32'(heldCode0), 32'h1C);
    applyStimulus(1'b1, 8'h1C, 1'b0);
    checkOutput("tp1 fill0", 32'(fill0), 32'd1);
    checkOutput("tp1 head0", 32'(keyCode0), 32'h1C);
    checkOutput("tp1 ext0", 32'(keyExt0), 32'h0);
    checkOutput("tp1 held cleared", 32'(heldCode0), 32'h0);
    checkOutput("tp1 fill1", 32'(fill1), 32'd3);
    repeat (HOLD + 1) applyStimulus(1'b0, 8'h00, 1'b0);

    // Repeats enqueued, then an E0-extended key
    applyClear();
    applyStimulus(1'b1, 8'h1C, 1'b0);
    applyStimulus(1'b1, 8'h1C, 1'b0);
    applyStimulus(1'b1, 8'hF0, 1'b0);
    applyStimulus(1'b1, 8'h1C, 1'b0);
    checkOutput("tp2 fill1", 32'(fill1), 32'd2);
    repeat (HOLD + 1) applyStimulus(1'b0, 8'h00, 1'b0);
    applyStimulus(1'b1, 8'hE0, 1'b0);
    applyStimulus(1'b1, 8'h75, 1'b0);
    applyStimulus(1'b1, 8'hE0, 1'b0);
    applyStimulus(1'b1, 8'hF0, 1'b0);
    applyStimulus(1'b1, 8'h75, 1'b0);
    checkOutput("tp2 fill0", 32'(fill0), 32'd2);
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("tp2 ext head code", 32'(keyCode0), 32'h75);
    checkOutput("tp2 ext head flag", 32'(keyExt0), 32'h1);
    repeat (HOLD + 1) applyStimulus(1'b0, 8'h00, 1'b0);

    // Hold-off window: bytes inside HOLD are dropped, including the last HOLD cycle
    applyClear();
    applyStimulus(1'b1, 8'h15, 1'b0);
    applyStimulus(1'b1, 8'hF0, 1'b0);
    applyStimulus(1'b1, 8'h15, 1'b0);
    applyStimulus(1'b1, 8'h24, 1'b0);
    applyStimulus(1'b1, 8'hF0, 1'b0);
    applyStimulus(1'b1, 8'h24, 1'b0);
    checkOutput("tp3 only first", 32'(fill0), 32'd1);
    repeat (HOLD - 4) applyStimulus(1'b0, 8'h00, 1'b0);
    applyStimulus(1'b1, 8'h24, 1'b0);
    checkOutput("tp3 last hold byte dropped", 32'(heldCode0), 32'h0);
    applyStimulus(1'b1, 8'h24, 1'b0);
    applyStimulus(1'b1, 8'hF0, 1'b0);
    applyStimulus(1'b1, 8'h24, 1'b0);
    checkOutput("tp3 second entry", 32'(fill0), 32'd2);
    repeat (HOLD + 1) applyStimulus(1'b0, 8'h00, 1'b0);

    // Overflow, ordered drain, and pointer wrap
    applyClear();
    keystroke(8'h15, 1'b0, 1'b0);
    keystroke(8'h24, 1'b0, 1'b0);
    keystroke(8'h2D, 1'b0, 1'b0);
    keystroke(8'h1C, 1'b0, 1'b0);
    keystroke(8'h75, 1'b0, 1'b0);
    checkOutput("tp4 fill full", 32'(fill0), 32'd4);
    checkOutput("tp4 overflow", 32'(overflow0), 32'h1);
    checkOutput("tp4 head first", 32'(keyCode0), 32'h15);
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("tp4 drain %0d", k), 32'(keyCode0), 32'(drain1[k]));
      applyStimulus(1'b0, 8'h00, 1'b1);
    end
    checkOutput("tp4 drained", 32'(keyValid0), 32'h0);
    keystroke(8'h33, 1'b0, 1'b0);
    keystroke(8'h34, 1'b0, 1'b0);
    keystroke(8'h35, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b1);
    keystroke(8'h36, 1'b0, 1'b0);
    keystroke(8'h3C, 1'b0, 1'b0);
    keystroke(8'h3B, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("tp4 wrap drain %0d", k), 32'(keyCode0), 32'(drain2[k]));
      applyStimulus(1'b0, 8'h00, 1'b1);
    end

    // Full FIFO: push and pop in the same cycle
    applyClear();
    keystroke(8'h15, 1'b0, 1'b0);
    keystroke(8'h24, 1'b0, 1'b0);
    keystroke(8'h2D, 1'b0, 1'b0);
    keystroke(8'h1C, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h43, 1'b0);
    applyStimulus(1'b1, 8'hF0, 1'b0);
    applyStimulus(1'b1, 8'h43, 1'b1);
    checkOutput("tp5 fill kept", 32'(fill0), 32'd4);
    checkOutput("tp5 no overflow", 32'(overflow0), 32'h0);
    checkOutput("tp5 next head", 32'(keyCode0), 32'h24);
    repeat (HOLD + 1) applyStimulus(1'b0, 8'h00, 1'b0);

    // Orphan break, reset mid-keystroke, clear with a partly full FIFO
    applyClear();
    applyStimulus(1'b1, 8'hF0, 1'b0);
    applyStimulus(1'b1, 8'h2D, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("tp6 orphan fill", 32'(fill0), 32'd0);
    checkOutput("tp6 orphan held", 32'(heldCode0), 32'h0);
    applyStimulus(1'b1, 8'h1C, 1'b0);
    checkOutput("tp6 make held", 32'(heldCode0), 32'h1C);
    applyReset();
    applyStimulus(1'b1, 8'hF0, 1'b0);
    applyStimulus(1'b1, 8'h1C, 1'b0);
    checkOutput("tp6 abandoned", 32'(fill0), 32'd0);
    keystroke(8'h15, 1'b0, 1'b0);
    keystroke(8'h24, 1'b0, 1'b0);
    keystroke(8'h2D, 1'b0, 1'b0);
    keystroke(8'h1C, 1'b0, 1'b0);
    keystroke(8'h75, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("tp6 fill three", 32'(fill0), 32'd3);
    checkOutput("tp6 overflow set", 32'(overflow0), 32'h1);
    applyClear();
    checkOutput("tp6 clear fill", 32'(fill0), 32'd0);
    checkOutput("tp6 clear overflow", 32'(overflow0), 32'h0);

    // Randomised byte stream with random consumer, occasional clear and reset
    for (int n = 0; n < 2500; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        applyClear();
      end else if ($urandom_range(0, 499) == 0) begin
        applyReset();
      end else begin
        applyStimulus(1'($urandom_range(0, 1)), pool[$urandom_range(0, 7)],
                      ($urandom_range(0, 3) == 0));
      end
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
